// File: rtl/shift_pkg.sv
// shift_pkg -- shared definitions for the shift-register family.
// Holds the two-state control encoding, the default word width and a helper
// for sizing bit counters. Used by sipo_rx8 and the parallel-load shifter.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width able to hold the values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_hold.sv
// sipo_hold -- output word register with valid/ack handshake and overrun flag.
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   clr     in   clears the sticky overrun flag
//   load    in   a completed word is offered on this edge
//   word    in   [WIDTH] completed word
//   p_ack   in   consumer acknowledge of the presented word
//   p_out   out  [WIDTH] last accepted word, stable while p_valid=1
//   p_valid out  p_out holds an unacknowledged word
//   overrun out  sticky: a completed word was dropped
module sipo_hold import shift_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             p_ack,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             overrun
);

  // A new word is accepted when the slot is empty or being freed on this edge.
  logic accept;
  assign accept = load && (!p_valid || p_ack);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_out   <= '0;
      p_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (accept) begin
        p_out   <= word;
        p_valid <= 1'b1;
      end else if (p_valid && p_ack) begin
        p_valid <= 1'b0;
      end

      // clr wins over a drop on the same edge; the receiver never offers a
      // word while clr is high, so the two cannot actually coincide.
      if (clr) begin
        overrun <= 1'b0;
      end else if (load && !accept) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sipo_rx8.sv
// sipo_rx8 -- serial-in / parallel-out receiver.
// Collects WIDTH qualified serial bits into a word and hands it to sipo_hold.
// Ports:
//   clk     in   system clock
//   rst_n   in   synchronous active-low reset
//   s_in    in   serial data bit
//   s_en    in   qualifies s_in; a bit is taken only when high
//   clr     in   abort a partial word and clear overrun
//   p_ack   in   consumer acknowledge
//   p_out   out  [WIDTH] last completed word
//   p_valid out  p_out holds an unacknowledged word
//   busy    out  1..WIDTH-1 bits currently held
//   overrun out  sticky dropped-word flag
module sipo_rx8 import shift_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_in,
  input  logic             s_en,
  input  logic             clr,
  input  logic             p_ack,
  output logic [WIDTH-1:0] p_out,
  output logic             p_valid,
  output logic             busy,
  output logic             overrun
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sreg, sreg_nx, shifted;
  logic             take, done;

  // A bit arriving together with clr is discarded.
  assign take = s_en && !clr;
  assign done = take && (cnt == CW'(WIDTH - 1));

  assign shifted = MSB_FIRST ? {sreg[WIDTH-2:0], s_in}
                             : {s_in, sreg[WIDTH-1:1]};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sreg_nx  = sreg;
    if (clr) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      sreg_nx  = '0;
    end else if (take) begin
      if (done) begin
        // Completed word leaves through 'shifted'; start the next one clean.
        state_nx = IDLE;
        cnt_nx   = '0;
        sreg_nx  = '0;
      end else begin
        state_nx = SHIFT;
        cnt_nx   = cnt + CW'(1);
        sreg_nx  = shifted;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sreg  <= sreg_nx;
    end
  end

  assign busy = (state == SHIFT);

  sipo_hold #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .load    (done),
    .word    (shifted),
    .p_ack   (p_ack),
    .p_out   (p_out),
    .p_valid (p_valid),
    .overrun (overrun)
  );

endmodule

// File: doc/sipo_rx8.md
SIPO_RX8 -- requirements
Module: sipo_rx8

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of bits per word (legal range 2..16).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = first received bit lands in p_out[WIDTH-1]; 0 = first bit lands in p_out[0].
REQ-003 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port s_in  input  1  serial data bit.
REQ-006 The block SHALL have port s_en  input  1  qualifies s_in; a bit is taken only on edges where s_en=1.
REQ-007 The block SHALL have port clr  input  1  synchronous abort of a partially received word.
REQ-008 The block SHALL have port p_ack  input  1  consumer acknowledge of the presented word.
REQ-009 The block SHALL have port p_out  output  WIDTH  last completed parallel word.
REQ-010 The block SHALL have port p_valid  output  1  p_out holds an unacknowledged word.
REQ-011 The block SHALL have port busy  output  1  a word is partially received (1..WIDTH-1 bits held).
REQ-012 The block SHALL have port overrun  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 The FSM SHALL have states IDLE (no bits held) and SHIFT (1..WIDTH-1 bits held); busy=1 exactly in SHIFT.
REQ-014 IDLE->SHIFT on s_en=1; SHIFT->SHIFT while the bit count stays below WIDTH; SHIFT->IDLE on the edge that takes bit WIDTH, or on clr.
REQ-015 The shift register and bit counter SHALL advance only on edges with s_en=1; s_en=0 holds all state (gaps of any length allowed).
REQ-016 With MSB_FIRST=1 the shift register SHALL shift left, inserting s_in at bit 0; with MSB_FIRST=0 it SHALL shift right, inserting at bit WIDTH-1.
REQ-017 On the edge taking bit WIDTH, the complete word (including that bit) SHALL be transferred to p_out and p_valid set to 1 on the following cycle; latency from last bit edge to p_valid=1 is one clock.
REQ-018 p_out SHALL remain stable while p_valid=1; p_valid SHALL clear on the edge where p_ack=1 and no new word completes.
REQ-019 p_ack while p_valid=0 SHALL be ignored.
REQ-020 Word completes while p_valid=1 and p_ack=1 on the same edge: new word SHALL be loaded, p_valid stays 1, overrun unchanged.
REQ-021 Word completes while p_valid=1 and p_ack=0: new word SHALL be dropped, p_out unchanged, overrun set to 1.
REQ-022 overrun SHALL clear only by reset or by clr=1.
REQ-023 clr=1 SHALL discard partial bits, zero the counter, return to IDLE, clear overrun; it SHALL NOT affect p_out or p_valid; an s_en bit on the same edge is discarded.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never exceed WIDTH.

Reset
REQ-025 On rst_n=0 at a clock edge: state=IDLE, counter=0, shift register=0, p_out=0, p_valid=0, busy=0, overrun=0.
REQ-026 Reset SHALL take priority over clr, s_en and p_ack; reset during SHIFT discards the partial word.
REQ-027 No output SHALL change asynchronously with rst_n.

Structure
REQ-028 State encoding (IDLE, SHIFT) and default WIDTH SHALL live in shared package shift_pkg, reused by the existing parallel-load shift register.
REQ-029 Output word register with valid/ack/overrun logic SHALL be sub-module sipo_hold; FSM, counter and shift register stay in sipo_rx8.

Verification
REQ-030 Reset then s_en=1 for 8 cycles with s_in = 1,0,1,0,1,0,1,1 (MSB_FIRST=1) -> p_out=8'hAB, p_valid=1 one cycle after the 8th bit, busy=0.
REQ-031 Same bits with MSB_FIRST=0 -> p_out=8'hD5.
REQ-032 Bits of 8'h3C delivered with s_en=0 gaps of 3 cycles between bits -> p_out=8'h3C, busy=1 throughout the gaps.
REQ-033 Hold p_ack=0, send 8'h11 then 8'h22 -> p_out stays 8'h11, overrun=1; then clr=1 -> overrun=0, p_valid still 1.
REQ-034 Send 8'h11, then assert p_ack on the edge that completes 8'h22 -> p_out=8'h22, p_valid=1, overrun=0.
REQ-035 After 5 bits assert rst_n=0 for one cycle, then send 8'hF0 -> p_out=8'hF0, no stale bits.
